gf180mcu_fd_sc_mcu9t5v0_oain1_pipe: RTL and testbench
=====================================================

Name: gf180mcu_fd_sc_mcu9t5v0_oain1_pipe

Overview:
- Parametrised, registered successor to the OAI31 cell family.
- Computes ZN = !((A[0] | … | A[N-1]) & B) over an N-wide OR group.
- Result passes through a STAGES-deep clock-enabled pipeline with an embedded scan chain and a fill-valid flag.
- Used as a characterisation/test macro and as a timing-closed OAI in registered datapaths of the 9-track 5V library.

Parameters:
- N, 3, width of the OR group (1..8); N=3 reproduces OAI31 logic.
- STAGES, 2, pipeline depth (1..4).
- RESET_VAL, 1'b1, reset value of every pipeline stage (the OAI idle output with A=0).

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- A  input  N  OR-group inputs.
- B  input  1  AND input.
- E  input  1  functional clock enable.
- SE  input  1  scan enable; overrides E.
- SI  input  1  scan-in serial data.
- Q  output  1  pipeline output, stage[STAGES-1].
- SO  output  1  scan-out; equals Q.
- QV  output  1  high once STAGES functional captures have occurred since reset or the last scan shift.

Behaviour:
- Combinational core: zn = ~((|A) & B), using Verilog reduction semantics.
  - B=0 gives zn=1 even if A contains X.
  - Any A bit =1 with B=1 gives zn=0.
- Reset (RST=1, asynchronous):
  - All stages load RESET_VAL; fill counter = 0.
  - Q=SO=RESET_VAL, QV=0.
  - Reset applies immediately mid-operation, independent of CLK. Release is synchronous in effect: the first capture is on the first rising CLK edge with RST=0.
- Modes per rising edge, priority top-down:
  - SE=1 (scan shift): stage[0] <= SI; stage[k] <= stage[k-1]; fill counter <= 0.
  - SE=0, E=1 (capture): stage[0] <= zn; stage[k] <= stage[k-1]; fill counter <= min(cnt+1, STAGES).
  - SE=0, E=0 (hold): all stages and the counter hold.
- Latency:
  - Q reflects zn sampled STAGES enabled edges earlier.
  - Hold cycles do not advance data.
- Fill counter:
  - Width $clog2(STAGES+1); saturates at STAGES and never wraps.
  - QV = (cnt == STAGES), registered, no combinational path from inputs.
- Simultaneous SE=1 and E=1: scan wins and the counter clears.
- Scan chain length is STAGES; SO is the last stage.
- STAGES=1: single flop; QV rises after the first capture.

Optional Feature:
- Macro: GF180MCU_FD_SC_MCU9T5V0_POWER_CHECK_EN
- Defined:
  - Adds ports VDD and VSS (inout, 1 bit), listed after SO.
  - While VDD!==1'b1 or VSS!==1'b0, Q, SO and QV drive 1'bx and the stages load 1'bx on every clock edge.
  - Once rails are valid, X stages persist until reset or until flushed by captures or scan.
- Undefined: no power ports; the rail check is absent.

Decomposition:
- Shared package gf180mcu_fd_sc_mcu9t5v0_pkg holds:
  - N_MAX=8 and STAGES_MAX=4 bounds.
  - The mode encoding typedef (SHIFT, CAPTURE, HOLD).
- Natural sub-module: gf180mcu_fd_sc_mcu9t5v0_oain1_func, the combinational N-input OAI core producing zn, reusable by future unregistered OAI-N1 cells.
- Pipeline, scan mux, counter and power check stay in the top.
- Elaboration check: N and STAGES are within the package bounds; out-of-range values are a fatal error.

Test Plan (N=3, STAGES=2 unless stated):
- Reset: RST pulsed asynchronously between edges → Q=1, QV=0 immediately, no clock edge required.
- Capture: E=1, A=3'b010, B=1 for 2 edges → Q=0 and QV=1 after the 2nd edge; then A=3'b000 → Q=1 two edges later.
- Hold: E=0 for 5 cycles with inputs toggling → Q and QV unchanged; resuming E=1 continues the pipeline with no lost or duplicated sample.
- Scan: SE=1, SI sequence 1,0 over 2 edges → SO=1 after edge 2, then 0 after edge 3 with SI=0; QV=0 throughout and after SE drops until 2 captures.
- Priority and X: SE=1 with E=1 → scan path taken, counter cleared. Separately, B=0 with A=3'bx1x → captured zn=1, not X.
- Power check (macro defined): VDD=0 → Q=SO=QV=X. Restore VDD=1 with 2 captures of A=0 → Q=1, QV=1. Macro undefined → no VDD/VSS ports elaborate.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_pkg.sv
// Shared definitions for the 9-track 5V registered OAI macros: parameter bounds
// and the per-edge pipeline mode encoding.
package gf180mcu_fd_sc_mcu9t5v0_pkg;

    localparam int N_MAX      = 8;
    localparam int STAGES_MAX = 4;

    typedef enum logic [1:0] {
        SHIFT   = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } mode_e;

    // Scan enable has priority over the functional enable.
    function automatic mode_e sel_mode(input logic se, input logic e);
        if (se)
            return SHIFT;
        else if (e)
            return CAPTURE;
        else
            return HOLD;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_oain1_pipe_if.sv
// Data/scan bundle of the registered OAI-N1 macro; the driver of A/B/E/SE/SI
// is the master, the macro itself is the slave.
interface gf180mcu_fd_sc_mcu9t5v0_oain1_pipe_if #(
    parameter int N = 3
);
    import gf180mcu_fd_sc_mcu9t5v0_pkg::*;

    logic [N-1:0] A;
    logic         B;
    logic         E;
    logic         SE;
    logic         SI;
    logic         Q;
    logic         SO;
    logic         QV;

    modport master (output A, B, E, SE, SI, input Q, SO, QV);
    modport slave  (input A, B, E, SE, SI, output Q, SO, QV);

endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_oain1_func.sv
// Combinational N-input OAI core: zn = ~((|a) & b). With b=0 the output is 1
// regardless of unknowns on a, following reduction/AND semantics.
module gf180mcu_fd_sc_mcu9t5v0_oain1_func
    import gf180mcu_fd_sc_mcu9t5v0_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] a,
    input  logic         b,
    output logic         zn
);

    assign zn = ~((|a) & b);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_oain1_pipe.sv
// Registered OAI-N1 with STAGES-deep clock-enabled pipeline, scan chain and
// fill-valid flag. Define GF180MCU_FD_SC_MCU9T5V0_POWER_CHECK_EN to add VDD/VSS rail checking.
module gf180mcu_fd_sc_mcu9t5v0_oain1_pipe
    import gf180mcu_fd_sc_mcu9t5v0_pkg::*;
#(
    parameter int   N         = 3,
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    gf180mcu_fd_sc_mcu9t5v0_oain1_pipe_if.slave     bus
`ifdef GF180MCU_FD_SC_MCU9T5V0_POWER_CHECK_EN
    ,
    inout  wire                                     VDD,
    inout  wire                                     VSS
`endif
);

    localparam int                CNT_W    = $clog2(STAGES + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(STAGES);

    if (N < 1 || N > N_MAX || STAGES < 1 || STAGES > STAGES_MAX) begin : g_param_check
        $fatal(1, "oain1_pipe: N=%0d or STAGES=%0d outside supported range", N, STAGES);
    end

    logic              zn;
    logic              pwr_ok;
    mode_e             mode;
    logic [STAGES-1:0] stage_d, stage_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              qv_d, qv_q;

    gf180mcu_fd_sc_mcu9t5v0_oain1_func #(.N(N)) u_func (
        .a  (bus.A),
        .b  (bus.B),
        .zn (zn)
    );

`ifdef GF180MCU_FD_SC_MCU9T5V0_POWER_CHECK_EN
    assign pwr_ok = (VDD === 1'b1) && (VSS === 1'b0);
`else
    assign pwr_ok = 1'b1;
`endif

    always_comb begin
        mode    = sel_mode(bus.SE, bus.E);
        stage_d = stage_q;
        cnt_d   = cnt_q;
        case (mode)
            SHIFT: begin
                stage_d[0] = bus.SI;
                for (int k = 1; k < STAGES; k++)
                    stage_d[k] = stage_q[k-1];
                cnt_d = '0;
            end
            CAPTURE: begin
                stage_d[0] = zn;
                for (int k = 1; k < STAGES; k++)
                    stage_d[k] = stage_q[k-1];
                if (cnt_q != CNT_FULL)
                    cnt_d = cnt_q + 1'b1;
            end
            default: ;
        endcase
        // Bad rails corrupt every stage; the fill count restarts so QV waits for a flush.
        if (!pwr_ok) begin
            stage_d = 'x;
            cnt_d   = '0;
        end
        qv_d = (cnt_d == CNT_FULL);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stage_q <= {STAGES{RESET_VAL}};
            cnt_q   <= '0;
            qv_q    <= 1'b0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            qv_q    <= qv_d;
        end
    end

    assign bus.Q  = pwr_ok ? stage_q[STAGES-1] : 1'bx;
    assign bus.SO = pwr_ok ? stage_q[STAGES-1] : 1'bx;
    assign bus.QV = pwr_ok ? qv_q : 1'bx;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0_oain1_pipe.sv
// Directed bench for the registered OAI-N1 macro (N=3, STAGES=2) with a
// queue-based pipeline scoreboard.
module tb_gf180mcu_fd_sc_mcu9t5v0_oain1_pipe;

    localparam int   N         = 3;
    localparam int   STAGES    = 2;
    localparam logic RESET_VAL = 1'b1;

    logic CLK;
    logic RST;
    int   nvec;
    int   nerr;
    logic exp_pipe[$];
    int   exp_cnt;

    gf180mcu_fd_sc_mcu9t5v0_oain1_pipe_if #(.N(N)) bus ();

`ifdef GF180MCU_FD_SC_MCU9T5V0_POWER_CHECK_EN
    logic vdd_drv;
    wire  VDD;
    wire  VSS;
    assign VDD = vdd_drv;
    assign VSS = 1'b0;
`endif

    gf180mcu_fd_sc_mcu9t5v0_oain1_pipe #(
        .N(N), .STAGES(STAGES), .RESET_VAL(RESET_VAL)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
`ifdef GF180MCU_FD_SC_MCU9T5V0_POWER_CHECK_EN
        ,
        .VDD (VDD),
        .VSS (VSS)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pipe = {};
        for (int i = 0; i < STAGES; i++)
            exp_pipe.push_back(RESET_VAL);
        exp_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".Q"},  bus.Q,  exp_pipe[0]);
        chk({tag, ".SO"}, bus.SO, exp_pipe[0]);
        chk({tag, ".QV"}, bus.QV, exp_cnt == STAGES);
    endtask

    // Drive one cycle of inputs, advance the scoreboard, then check after the edge.
    task automatic step(input string tag, input logic [N-1:0] a, input logic b,
                        input logic e, input logic se, input logic si);
        logic zn_exp;
        bus.A  = a;
        bus.B  = b;
        bus.E  = e;
        bus.SE = se;
        bus.SI = si;
        zn_exp = (b === 1'b0) ? 1'b1 : ~((|a) & b);
        if (se) begin
            void'(exp_pipe.pop_front());
            exp_pipe.push_back(si);
            exp_cnt = 0;
        end else if (e) begin
            void'(exp_pipe.pop_front());
            exp_pipe.push_back(zn_exp);
            if (exp_cnt < STAGES)
                exp_cnt++;
        end
        @(posedge CLK);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        nvec   = 0;
        nerr   = 0;
        RST    = 1'b1;
        bus.A  = '0;
        bus.B  = 1'b0;
        bus.E  = 1'b0;
        bus.SE = 1'b0;
        bus.SI = 1'b0;
`ifdef GF180MCU_FD_SC_MCU9T5V0_POWER_CHECK_EN
        vdd_drv = 1'b1;
`endif
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge CLK);
        RST = 1'b0;

        // Fill with A=010,B=1 then flush with A=000
        step("cap1", 3'b010, 1'b1, 1'b1, 1'b0, 1'b0);
        step("cap2", 3'b010, 1'b1, 1'b1, 1'b0, 1'b0);
        step("cap3", 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
        step("cap4", 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);

        // Load a 0 into stage 0, then hold with inputs toggling
        step("pre_hold", 3'b100, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step("hold", 3'(i + 1), i[0], 1'b0, 1'b0, ~i[0]);
        step("resume1", 3'b111, 1'b0, 1'b1, 1'b0, 1'b0);
        step("resume2", 3'b001, 1'b1, 1'b1, 1'b0, 1'b0);
        step("resume3", 3'b110, 1'b1, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges
        @(negedge CLK);
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        check_outputs("async_rst");
        @(negedge CLK);
        RST = 1'b0;

        // Scan shift 1,0 then 0; SE=1 with E=1 in the middle
        step("cap_pre_scan1", 3'b001, 1'b1, 1'b1, 1'b0, 1'b0);
        step("cap_pre_scan2", 3'b001, 1'b1, 1'b1, 1'b0, 1'b0);
        step("scan1", 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
        step("scan2_prio", 3'b111, 1'b1, 1'b1, 1'b1, 1'b0);
        step("scan3", 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        step("post_scan_cap1", 3'b010, 1'b1, 1'b1, 1'b0, 1'b0);
        step("post_scan_cap2", 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);

        // B=0 masks unknowns on A
        step("xmask1", 3'bx1x, 1'b0, 1'b1, 1'b0, 1'b0);
        step("xmask2", 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef GF180MCU_FD_SC_MCU9T5V0_POWER_CHECK_EN
        @(negedge CLK);
        vdd_drv = 1'b0;
        #1;
        chk("pwr_bad.Q",  bus.Q,  1'bx);
        chk("pwr_bad.SO", bus.SO, 1'bx);
        chk("pwr_bad.QV", bus.QV, 1'bx);
        @(posedge CLK);
        #1;
        vdd_drv = 1'b1;
        exp_pipe = {};
        for (int i = 0; i < STAGES; i++)
            exp_pipe.push_back(1'bx);
        exp_cnt = 0;
        step("pwr_flush1", 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
        step("pwr_flush2", 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
